// File: rtl/fill_rect.sv
// Rectangle fill engine: paints a clamped, axis-aligned rectangle on the framebuffer,
// one pixel per clock, column-major, behind a level-sensitive start/done handshake.
module fill_rect #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] x1,
  input  logic [6:0] y1,
  input  logic [2:0] colour,
  input  logic       stripe,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;
  localparam logic [XW-1:0] X_MAX = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t        state_q, state_n;
  logic [XW-1:0] x_q, x_n, xb_q, xb_n;
  logic [YW-1:0] y_q, y_n, ya_q, ya_n, yb_q, yb_n;
  logic [CW-1:0] colour_q, colour_n, pix_q, pix_n;
  logic          stripe_q, stripe_n;
  logic          plot_q, plot_n;
  logic          done_q, done_n;

  logic [XW-1:0] xa_c, xb_c, x_inc_c;
  logic [YW-1:0] ya_c, yb_c;

  // Clamp requested corners onto the visible framebuffer
  assign xa_c    = (x0 > X_MAX) ? X_MAX : x0;
  assign xb_c    = (x1 > X_MAX) ? X_MAX : x1;
  assign ya_c    = (y0 > Y_MAX) ? Y_MAX : y0;
  assign yb_c    = (y1 > Y_MAX) ? Y_MAX : y1;
  assign x_inc_c = x_q + XW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      ya_q     <= '0;
      xb_q     <= '0;
      yb_q     <= '0;
      colour_q <= '0;
      stripe_q <= 1'b0;
      pix_q    <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      ya_q     <= ya_n;
      xb_q     <= xb_n;
      yb_q     <= yb_n;
      colour_q <= colour_n;
      stripe_q <= stripe_n;
      pix_q    <= pix_n;
      plot_q   <= plot_n;
      done_q   <= done_n;
    end
  end

  // Next state and next registered outputs; x/y counters double as the pixel address
  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    y_n      = y_q;
    ya_n     = ya_q;
    xb_n     = xb_q;
    yb_n     = yb_q;
    colour_n = colour_q;
    stripe_n = stripe_q;
    pix_n    = pix_q;
    plot_n   = 1'b0;
    done_n   = done_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ya_n     = ya_c;
          xb_n     = xb_c;
          yb_n     = yb_c;
          colour_n = colour;
          stripe_n = stripe;
          if ((xa_c > xb_c) || (ya_c > yb_c)) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = FILL;
            plot_n  = 1'b1;
            x_n     = xa_c;
            y_n     = ya_c;
            pix_n   = stripe ? xa_c[CW-1:0] : colour;
          end
        end
      end
      FILL: begin
        if ((x_q == xb_q) && (y_q == yb_q)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          plot_n = 1'b1;
          if (y_q == yb_q) begin
            // Column finished: wrap to the top row of the next column
            y_n   = ya_q;
            x_n   = x_inc_c;
            pix_n = stripe_q ? x_inc_c[CW-1:0] : colour_q;
          end else begin
            y_n = y_q + YW'(1);
          end
        end
      end
      DONE: begin
        if (!start) begin
          state_n = IDLE;
          done_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        done_n  = 1'b0;
      end
    endcase
  end

  assign done       = done_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = pix_q;
  assign vga_plot   = plot_q;

endmodule

// File: tb/tb_fill_rect.sv
// Self-checking bench for fill_rect: a per-cycle expected-output queue built from the
// rectangle rules, checked every cycle, plus directed literal checks on key cycles.
module tb_fill_rect;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x0 = '0, x1 = '0;
  logic [6:0] y0 = '0, y1 = '0;
  logic [2:0] colour = '0;
  logic       stripe = 1'b0;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  fill_rect dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .colour(colour), .stripe(stripe),
    .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       done;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t e_cur;
  logic rest_done = 1'b0;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  // Observations gathered by wait_done
  int         first_x, first_y, first_c;
  int         last_x, last_y, last_c;
  int         c95;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Per-cycle compare against the expected queue; idle expectation once it drains
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) e_cur = exp_q.pop_front();
      else begin
        e_cur.plot = 1'b0; e_cur.x = '0; e_cur.y = '0; e_cur.c = '0; e_cur.done = rest_done;
      end
      n_checks++;
      if (vga_plot === e_cur.plot && done === e_cur.done &&
          (!e_cur.plot || (vga_x === e_cur.x && vga_y === e_cur.y && vga_colour === e_cur.c)))
        n_pass++;
      else
        $display("FAIL cycle_cmp t=%0t: got plot=%0b done=%0b (%0d,%0d) c=%0d, expected plot=%0b done=%0b (%0d,%0d) c=%0d",
                 $time, vga_plot, done, vga_x, vga_y, vga_colour,
                 e_cur.plot, e_cur.done, e_cur.x, e_cur.y, e_cur.c);
    end
  end

  // Drive a request and build the expected trace: column-major pixels, then done
  task automatic launch(input int ax0, input int ay0, input int ax1, input int ay1,
                        input logic [2:0] col, input logic str);
    int xa, xb, ya, yb;
    cyc_t r;
    @(negedge clk); #1;
    x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
    colour = col; stripe = str; start = 1'b1;
    xa = (ax0 > 159) ? 159 : ax0;
    xb = (ax1 > 159) ? 159 : ax1;
    ya = (ay0 > 119) ? 119 : ay0;
    yb = (ay1 > 119) ? 119 : ay1;
    for (int x = xa; x <= xb; x++) begin
      for (int y = ya; y <= yb; y++) begin
        r.plot = 1'b1; r.x = 8'(x); r.y = 7'(y); r.c = str ? 3'(x) : col; r.done = 1'b0;
        exp_q.push_back(r);
      end
    end
    r.plot = 1'b0; r.x = '0; r.y = '0; r.c = '0; r.done = 1'b1;
    exp_q.push_back(r);
    rest_done = 1'b1;
  endtask

  // Count cycles/plots until done, optionally disturbing inputs mid-fill
  task automatic wait_done(input int bound, input logic disturb,
                           output int done_cyc, output int plots);
    int cyc;
    cyc = 0; plots = 0; done_cyc = -1;
    first_x = -1; first_y = -1; first_c = -1; c95 = -1;
    while (cyc < bound) begin
      @(negedge clk); #1;
      cyc++;
      if (vga_plot) begin
        plots++;
        if (plots == 1) begin first_x = vga_x; first_y = vga_y; first_c = vga_colour; end
        last_x = vga_x; last_y = vga_y; last_c = vga_colour;
        if (vga_x == 8'd9 && vga_y == 7'd5) c95 = vga_colour;
      end
      if (disturb && cyc == 2) begin start = 1'b0; colour = ~colour; x1 = 8'd100; end
      if (disturb && cyc == 3) start = 1'b1;
      if (done) begin done_cyc = cyc; break; end
    end
  endtask

  task automatic drop_start(input string name);
    @(negedge clk); #1;
    start = 1'b0;
    rest_done = 1'b0;
    @(negedge clk); #1;
    check({name, "_done_drop"}, int'(done), 0);
  endtask

  initial begin
    int dc, np, held;
    #1 rst_n = 1'b0;
    #2;
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_x", int'(vga_x), 0);
    check("rst_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full screen, stripes
    launch(0, 0, 159, 119, 3'd0, 1'b1);
    check("model_len", exp_q.size(), 19201);
    check("model_first_c", int'(exp_q[0].c), 0);
    check("model_95", {int'(exp_q[9*120+5].x), int'(exp_q[9*120+5].y), int'(exp_q[9*120+5].c)} == {9, 5, 1} ? 1 : 0, 1);
    check("model_last", (exp_q[19199].x == 8'd159 && exp_q[19199].y == 7'd119 && exp_q[19199].c == 3'd7) ? 1 : 0, 1);
    wait_done(20000, 1'b0, dc, np);
    check("full_plots", np, 19200);
    check("full_done_cyc", dc, 19201);
    check("full_first", first_x * 10000 + first_y * 10 + first_c, 0);
    check("full_c95", c95, 1);
    check("full_last", last_x * 10000 + last_y * 10 + last_c, 159 * 10000 + 119 * 10 + 7);
    repeat (9) begin @(negedge clk); #1; end
    check("full_plot_c19210", int'(vga_plot), 0);
    check("full_done_c19210", int'(done), 1);
    drop_start("full");

    // Small rectangle, solid colour, inputs disturbed mid-fill
    launch(10, 20, 12, 21, 3'b101, 1'b0);
    wait_done(50, 1'b1, dc, np);
    check("small_plots", np, 6);
    check("small_done_cyc", dc, 7);
    check("small_first", first_x * 10000 + first_y * 10 + first_c, 10 * 10000 + 20 * 10 + 5);
    check("small_last", last_x * 10000 + last_y * 10 + last_c, 12 * 10000 + 21 * 10 + 5);
    held = 0;
    repeat (5) begin @(negedge clk); #1; held += int'(vga_plot); end
    check("hold_plots", held, 0);
    check("hold_done", int'(done), 1);
    drop_start("small");

    // Clamped corner
    launch(158, 118, 200, 127, 3'd2, 1'b0);
    wait_done(50, 1'b0, dc, np);
    check("clamp_plots", np, 4);
    check("clamp_done_cyc", dc, 5);
    check("clamp_last", last_x * 1000 + last_y, 159 * 1000 + 119);
    drop_start("clamp");

    // Empty rectangle
    launch(50, 10, 40, 20, 3'd4, 1'b0);
    wait_done(50, 1'b0, dc, np);
    check("empty_plots", np, 0);
    check("empty_done_cyc", dc, 1);
    drop_start("empty");

    // Single pixel
    launch(5, 7, 5, 7, 3'b011, 1'b0);
    wait_done(50, 1'b0, dc, np);
    check("single_plots", np, 1);
    check("single_done_cyc", dc, 2);
    check("single_pix", first_x * 10000 + first_y * 10 + first_c, 5 * 10000 + 7 * 10 + 3);
    drop_start("single");

    // Reset at pixel 500 of a full fill
    launch(0, 0, 159, 119, 3'd6, 1'b0);
    np = 0;
    for (int i = 0; i < 1000 && np < 500; i++) begin
      @(negedge clk); #1;
      np += int'(vga_plot);
    end
    check("pre_reset_plots", np, 500);
    exp_q.delete();
    rest_done = 1'b0;
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_plot", int'(vga_plot), 0);
    check("async_rst_done", int'(done), 0);
    held = 0;
    repeat (5) begin @(negedge clk); #1; held += int'(vga_plot); end
    check("rst_held_plots", held, 0);
    rst_n = 1'b1;
    held = 0;
    repeat (5) begin @(negedge clk); #1; held += int'(vga_plot) + int'(done); end
    check("post_rst_idle", held, 0);

    // Clean restart after abort
    launch(5, 7, 6, 7, 3'b001, 1'b1);
    wait_done(50, 1'b0, dc, np);
    check("restart_plots", np, 2);
    check("restart_done_cyc", dc, 3);
    check("restart_last", last_x * 10000 + last_y * 10 + last_c, 6 * 10000 + 7 * 10 + 6);
    drop_start("restart");
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
